// File: rtl/finc_fdec_monitor_pkg.sv
// finc_fdec_monitor_pkg
//   Shared definitions for the FINC/FDEC step monitor: FSM state encoding,
//   violationCode values, default parameter values and a counter-width helper.
package finc_fdec_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH_INC = 2'd1,
    ST_HIGH_DEC = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam logic [1:0] VC_NONE        = 2'd0;
  localparam logic [1:0] VC_BOTH_HIGH   = 2'd1;
  localparam logic [1:0] VC_SHORT_PULSE = 2'd2;
  localparam logic [1:0] VC_SHORT_GAP   = 2'd3;

  localparam int unsigned DEF_MIN_PULSE_CYCLES = 4;
  localparam int unsigned DEF_MIN_GAP_CYCLES   = 8;
  localparam int unsigned DEF_ACC_WIDTH        = 16;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous level into clk.
//   Ports: clk (clock), rst (async active-high reset, forces output 0),
//          d (asynchronous input), q (synchronized output).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/finc_fdec_monitor.sv
// finc_fdec_monitor
//   Watches the asynchronous FINC/FDEC step-request pins, qualifies each pulse
//   against a minimum high time and minimum inter-pulse gap, and keeps a
//   saturating signed net step count plus sticky protocol-violation flags.
//   Ports:
//     clkInternal   - sole clock
//     rstInternal   - async active-high reset; deassertion expected to be
//                     synchronous to clkInternal
//     FINC, FDEC    - asynchronous step request pins
//     clearStats    - synchronous clear of stepCount and sticky flags
//     stepCount     - signed net count of accepted increments minus decrements
//     incPulse      - one-cycle strobe per accepted FINC pulse
//     decPulse      - one-cycle strobe per accepted FDEC pulse
//     violation     - sticky: any protocol violation seen
//     violationCode - most recent violation (none/both high/short pulse/short gap)
//     saturated     - sticky: stepCount clipped at a limit
module finc_fdec_monitor
  import finc_fdec_monitor_pkg::*;
#(
  parameter int unsigned MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int unsigned MIN_GAP_CYCLES   = DEF_MIN_GAP_CYCLES,
  parameter int unsigned ACC_WIDTH        = DEF_ACC_WIDTH
) (
  input  logic                        clkInternal,
  input  logic                        rstInternal,
  input  logic                        FINC,
  input  logic                        FDEC,
  input  logic                        clearStats,
  output logic signed [ACC_WIDTH-1:0] stepCount,
  output logic                        incPulse,
  output logic                        decPulse,
  output logic                        violation,
  output logic [1:0]                  violationCode,
  output logic                        saturated
);

  localparam int unsigned PW = cnt_bits(MIN_PULSE_CYCLES);
  localparam int unsigned GW = cnt_bits(MIN_GAP_CYCLES);

  localparam logic [PW-1:0] PULSE_MIN = PW'(MIN_PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_ONE = PW'(1);
  localparam logic [GW-1:0] GAP_MIN   = GW'(MIN_GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] ACC_NEG_ONE = '1;

  logic s_inc;
  logic s_dec;

  sync2 u_sync_inc (
    .clk (clkInternal),
    .rst (rstInternal),
    .d   (FINC),
    .q   (s_inc)
  );

  sync2 u_sync_dec (
    .clk (clkInternal),
    .rst (rstInternal),
    .d   (FDEC),
    .q   (s_dec)
  );

  state_t        state_q, state_d;
  logic [PW-1:0] width_q, width_d;
  logic [GW-1:0] gap_q,   gap_d;
  // Set once both pins are seen high together; the FSM is frozen until both
  // pins are low again so the overlapping pulse is never measured.
  logic          discard_q, discard_d;
  logic          acc_inc_q, acc_inc_d;
  logic          acc_dec_q, acc_dec_d;
  logic          viol_evt;
  logic [1:0]    viol_code;
  logic [GW-1:0] gap_next;

  assign gap_next = gap_q + GAP_ONE;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    gap_d     = gap_q;
    discard_d = discard_q;
    acc_inc_d = 1'b0;
    acc_dec_d = 1'b0;
    viol_evt  = 1'b0;
    viol_code = VC_NONE;

    if (s_inc && s_dec) begin
      if (!discard_q) begin
        viol_evt  = 1'b1;
        viol_code = VC_BOTH_HIGH;
      end
      discard_d = 1'b1;
    end else if (discard_q) begin
      if (!s_inc && !s_dec) begin
        discard_d = 1'b0;
        state_d   = ST_GAP;
        gap_d     = GAP_ONE;
        width_d   = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_inc) begin
            state_d = ST_HIGH_INC;
            width_d = PULSE_ONE;
          end else if (s_dec) begin
            state_d = ST_HIGH_DEC;
            width_d = PULSE_ONE;
          end
        end

        ST_HIGH_INC: begin
          if (s_inc) begin
            if (width_q < PULSE_MIN) width_d = width_q + PULSE_ONE;
          end else begin
            if (width_q >= PULSE_MIN) begin
              acc_inc_d = 1'b1;
            end else begin
              viol_evt  = 1'b1;
              viol_code = VC_SHORT_PULSE;
            end
            state_d = ST_GAP;
            gap_d   = GAP_ONE;
            width_d = '0;
          end
        end

        ST_HIGH_DEC: begin
          if (s_dec) begin
            if (width_q < PULSE_MIN) width_d = width_q + PULSE_ONE;
          end else begin
            if (width_q >= PULSE_MIN) begin
              acc_dec_d = 1'b1;
            end else begin
              viol_evt  = 1'b1;
              viol_code = VC_SHORT_PULSE;
            end
            state_d = ST_GAP;
            gap_d   = GAP_ONE;
            width_d = '0;
          end
        end

        ST_GAP: begin
          if (s_inc) begin
            viol_evt  = 1'b1;
            viol_code = VC_SHORT_GAP;
            state_d   = ST_HIGH_INC;
            width_d   = PULSE_ONE;
            gap_d     = '0;
          end else if (s_dec) begin
            viol_evt  = 1'b1;
            viol_code = VC_SHORT_GAP;
            state_d   = ST_HIGH_DEC;
            width_d   = PULSE_ONE;
            gap_d     = '0;
          end else if (gap_next >= GAP_MIN) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_next;
          end
        end

        default: begin
          state_d = ST_IDLE;
          width_d = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkInternal or posedge rstInternal) begin
    if (rstInternal) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      gap_q     <= '0;
      discard_q <= 1'b0;
      acc_inc_q <= 1'b0;
      acc_dec_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      discard_q <= discard_d;
      acc_inc_q <= acc_inc_d;
      acc_dec_q <= acc_dec_d;
    end
  end

  // Acceptance is pipelined one cycle behind the FSM decision so the strobe
  // and the count change appear together.
  always_ff @(posedge clkInternal or posedge rstInternal) begin
    if (rstInternal) begin
      stepCount <= '0;
      incPulse  <= 1'b0;
      decPulse  <= 1'b0;
      saturated <= 1'b0;
    end else begin
      incPulse <= acc_inc_q;
      decPulse <= acc_dec_q;
      if (clearStats) begin
        saturated <= 1'b0;
        if (acc_inc_q)      stepCount <= ACC_ONE;
        else if (acc_dec_q) stepCount <= ACC_NEG_ONE;
        else                stepCount <= '0;
      end else if (acc_inc_q) begin
        if (stepCount == ACC_MAX) saturated <= 1'b1;
        else                      stepCount <= stepCount + ACC_ONE;
      end else if (acc_dec_q) begin
        if (stepCount == ACC_MIN) saturated <= 1'b1;
        else                      stepCount <= stepCount - ACC_ONE;
      end
    end
  end

  // A violation in the same cycle as clearStats wins over the clear.
  always_ff @(posedge clkInternal or posedge rstInternal) begin
    if (rstInternal) begin
      violation     <= 1'b0;
      violationCode <= VC_NONE;
    end else if (viol_evt) begin
      violation     <= 1'b1;
      violationCode <= viol_code;
    end else if (clearStats) begin
      violation     <= 1'b0;
      violationCode <= VC_NONE;
    end
  end

endmodule
